alu_64: RTL and testbench
=========================

// Module: alu_64
// PURPOSE
// - 64-bit two's-complement ALU for the datapath execute stage: pass-B, add, subtract, AND, OR, XOR.
// - Produces result plus negative/zero/overflow/carry_out flags, registered once (1-cycle latency).
// - Built from ripple-carry bit slices.
// PARAMETERS
// - none; width fixed at 64, opcode width fixed at 3.
// PORTS
// - clk        in   1   single clock, rising-edge
// - reset      in   1   asynchronous, active-high; clears all output registers
// - A          in   64  operand A, two's complement
// - B          in   64  operand B, two's complement
// - cntrl      in   3   operation select (encoding below)
// - result     out  64  registered operation result
// - negative   out  1   registered result[63]
// - zero       out  1   registered (result == 0)
// - overflow   out  1   registered signed overflow of add/sub
// - carry_out  out  1   registered carry out of bit 63 for add/sub
// BEHAVIOUR
// - cntrl encoding:
//   - 000 PASS_B: B
//   - 010 ADD: A+B
//   - 011 SUB: A-B
//   - 100 AND: A&B
//   - 101 OR: A|B
//   - 110 XOR: A^B
//   - 001, 111 (reserved): result = 0
// - SUB is computed as A + ~B + 1: B is inverted per bit, and carry-in to bit 0 is 1. ADD uses carry-in 0.
// - Ripple carry: c[i] = carry out of bit i; carry_out = c[63]; overflow = c[63] ^ c[62].
// - Non-arithmetic ops (pass, logic, reserved) force carry_out = 0 and overflow = 0.
// - negative = result[63] and zero = ~|result, for every op including reserved.
//   Reserved ops therefore give zero = 1, negative = 0.
// - All arithmetic is modulo 2^64; no saturation.
// - Timing:
//   - Combinational next-state computed from the current A/B/cntrl.
//   - Outputs update on the rising clk edge after inputs are applied (latency 1, throughput 1/cycle).
//   - The pipeline has no stall or valid handshake; a new op is accepted every cycle.
// - Reset:
//   - Asserting reset clears result and all four flags to 0 immediately, without waiting for clk. This includes zero = 0 during reset.
//   - On the first rising edge after deassertion, the outputs load the ALU function of the current inputs.
//   - Reset mid-stream discards the in-flight result.
// - Changing cntrl and operands in the same cycle is legal; the registered outputs reflect the new combination one edge later.
// STRUCTURE
// - Package alu_pkg: typedef enum logic [2:0] alu_op_e with values ALU_PASS_B, ALU_ADD, ALU_SUBTRACT, ALU_AND, ALU_OR, ALU_XOR.
// - Sub-module alu_bit_slice, instantiated 64x, contains:
//   - a full adder (a, b_eff, cin -> sum, cout)
//   - a logic unit selecting b, a&b, a|b or a^b
//   - a 2:1 select between the adder sum and the logic-unit output
// - Top level holds:
//   - opcode decode (sub, arith_sel, logic_sel)
//   - B inversion
//   - carry chain
//   - flag logic, including a tree reduction for zero
//   - output register bank with async reset
// TESTING
// - Reset: assert reset mid-operation -> all outputs 0 immediately; after release, the next edge shows the live op.
// - ADD:
//   - A=10000, B=10000 -> result=20000, all flags 0.
//   - A=B=0x7FFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE, negative=1, overflow=1, carry_out=0.
//   - A=B=0x8000_0000_0000_0001 -> result=2, overflow=1, carry_out=1, negative=0.
// - SUB:
//   - A=37912, B=84021 -> result=-46109, negative=1, carry_out=0, overflow=0.
//   - A=5, B=5 -> result=0, zero=1, carry_out=1.
//   - A=5, B=-5 -> result=10, carry_out=0.
// - Logic ops with A=0x7FFF_FFFF_FFFF_FFFF, B=0:
//   - AND -> 0, zero=1.
//   - OR -> 0x7FFF_FFFF_FFFF_FFFF.
//   - XOR -> 0x7FFF_FFFF_FFFF_FFFF.
//   - In all three cases carry_out=0 and overflow=0.
// - PASS_B and reserved ops:
//   - 100 random A/B with cntrl=000 -> result==B, negative==B[63], zero==(B==0).
//   - cntrl=001 and cntrl=111 -> result=0, zero=1.
// - Latency: back-to-back ops on consecutive cycles -> each result appears exactly one edge after its inputs.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the 64-bit execute-stage ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_PASS_B   = 3'b000,
    ALU_ADD      = 3'b010,
    ALU_SUBTRACT = 3'b011,
    ALU_AND      = 3'b100,
    ALU_OR       = 3'b101,
    ALU_XOR      = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    LS_B,
    LS_AND,
    LS_OR,
    LS_XOR
  } logic_sel_e;

endpackage

// File: rtl/alu_bit_slice.sv
// One bit of the ALU: full adder, logic unit and
// a 2:1 select between them.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       b_eff,
  input  logic       cin,
  input  logic       arith_sel,
  input  logic_sel_e logic_sel,
  output logic       y,
  output logic       cout
);

  logic sum;
  logic lu;

  assign sum  = a ^ b_eff ^ cin;
  assign cout = (a & b_eff) | (cin & (a ^ b_eff));

  always_comb begin
    lu = b;
    unique case (logic_sel)
      LS_B:   lu = b;
      LS_AND: lu = a & b;
      LS_OR:  lu = a | b;
      LS_XOR: lu = a ^ b;
      default: lu = b;
    endcase
  end

  assign y = arith_sel ? sum : lu;

endmodule

// File: rtl/alu_64.sv
// 64-bit ripple-carry ALU with flags; all outputs
// registered once behind an async active-high reset.
module alu_64
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [2:0]  cntrl,
  output logic [63:0] result,
  output logic        negative,
  output logic        zero,
  output logic        overflow,
  output logic        carry_out
);

  logic       sub;
  logic       arith_sel;
  logic       valid;
  logic_sel_e logic_sel;

  always_comb begin
    sub       = 1'b0;
    arith_sel = 1'b0;
    logic_sel = LS_B;
    valid     = 1'b1;
    unique case (cntrl)
      ALU_PASS_B:   logic_sel = LS_B;
      ALU_ADD:      arith_sel = 1'b1;
      ALU_SUBTRACT: begin
        arith_sel = 1'b1;
        sub       = 1'b1;
      end
      ALU_AND:      logic_sel = LS_AND;
      ALU_OR:       logic_sel = LS_OR;
      ALU_XOR:      logic_sel = LS_XOR;
      default:      valid = 1'b0;
    endcase
  end

  logic [63:0] b_eff;
  logic [64:0] carry;
  logic [63:0] slice_y;

  assign b_eff    = B ^ {64{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < 64; i++) begin : g_slice
    alu_bit_slice u_slice (
      .a         (A[i]),
      .b         (B[i]),
      .b_eff     (b_eff[i]),
      .cin       (carry[i]),
      .arith_sel (arith_sel),
      .logic_sel (logic_sel),
      .y         (slice_y[i]),
      .cout      (carry[i+1])
    );
  end

  logic [63:0] res_next;
  logic        cout_next;
  logic        ovf_next;

  assign res_next  = valid ? slice_y : '0;
  assign cout_next = arith_sel & carry[64];
  assign ovf_next  = arith_sel & (carry[64] ^ carry[63]);

  // Balanced OR tree in heap layout: leaves at 63..126, root at 0.
  logic [126:0] node;

  for (genvar i = 0; i < 64; i++) begin : g_leaf
    assign node[63+i] = res_next[i];
  end

  for (genvar k = 0; k < 63; k++) begin : g_tree
    assign node[k] = node[2*k+1] | node[2*k+2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      result    <= res_next;
      negative  <= res_next[63];
      zero      <= ~node[0];
      overflow  <= ovf_next;
      carry_out <= cout_next;
    end
  end

endmodule

// File: tb/tb_alu_64.sv
// Random and directed checks of alu_64 against an
// arithmetic reference model.
module tb_alu_64;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] A;
  logic [63:0] B;
  logic [2:0]  cntrl;
  logic [63:0] result;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_64 dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .cntrl     (cntrl),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  // Packed view {result, negative, zero, overflow, carry_out}.
  function automatic logic [67:0] observed();
    return {result, negative, zero, overflow, carry_out};
  endfunction

  function automatic logic [67:0] model(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [2:0]  op
  );
    logic [64:0] s;
    logic [63:0] r;
    logic        v;
    logic        c;
    r = '0;
    v = 1'b0;
    c = 1'b0;
    case (op)
      3'b000: r = b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0];
        c = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      3'b011: begin
        s = {1'b0, a} + {1'b0, ~b} + 65'd1;
        r = s[63:0];
        c = s[64];
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: r = '0;
    endcase
    return {r, r[63], (r == 64'd0), v, c};
  endfunction

  task automatic check(
    input string       tag,
    input logic [67:0] got,
    input logic [67:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got res=%h nzvc=%b, want res=%h nzvc=%b",
               tag, got[67:4], got[3:0], exp[67:4], exp[3:0]);
    end
  endtask

  logic [67:0] prev_exp;

  // Drive at negedge, confirm old output still held, check after edge.
  task automatic run_op(
    input string       tag,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [2:0]  op,
    input logic [67:0] exp
  );
    @(negedge clk);
    A     = a;
    B     = b;
    cntrl = op;
    #1;
    check({tag, "_hold"}, observed(), prev_exp);
    @(posedge clk);
    #1;
    check(tag, observed(), exp);
    prev_exp = exp;
  endtask

  task automatic run_model(
    input string       tag,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [2:0]  op
  );
    run_op(tag, a, b, op, model(a, b, op));
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINP = 64'h8000_0000_0000_0001;

  initial begin
    reset = 1'b1;
    A     = 64'd10000;
    B     = 64'd10000;
    cntrl = 3'b010;
    #2;
    check("reset_init", observed(), 68'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    @(posedge clk);
    #1;
    prev_exp = {64'd20000, 4'b0000};
    check("post_reset", observed(), prev_exp);

    run_op("add_small", 64'd10000, 64'd10000, 3'b010,
           {64'd20000, 4'b0000});
    run_op("add_maxp", MAXP, MAXP, 3'b010,
           {64'hFFFF_FFFF_FFFF_FFFE, 4'b1010});
    run_op("add_minp", MINP, MINP, 3'b010,
           {64'd2, 4'b0011});
    run_op("sub_neg", 64'd37912, 64'd84021, 3'b011,
           {-64'sd46109, 4'b1000});
    run_op("sub_eq", 64'd5, 64'd5, 3'b011,
           {64'd0, 4'b0101});
    run_op("sub_m5", 64'd5, -64'sd5, 3'b011,
           {64'd10, 4'b0000});
    run_op("and_z", MAXP, 64'd0, 3'b100, {64'd0, 4'b0100});
    run_op("or_max", MAXP, 64'd0, 3'b101, {MAXP, 4'b0000});
    run_op("xor_max", MAXP, 64'd0, 3'b110, {MAXP, 4'b0000});
    run_op("rsv_001", MAXP, MINP, 3'b001, {64'd0, 4'b0100});
    run_op("rsv_111", MINP, MAXP, 3'b111, {64'd0, 4'b0100});
    run_op("pass_zero", MAXP, 64'd0, 3'b000, {64'd0, 4'b0100});

    for (int i = 0; i < 100; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = rnd64();
      rb = rnd64();
      run_op("pass_b", ra, rb, 3'b000,
             {rb, rb[63], (rb == 64'd0), 2'b00});
    end

    for (int i = 0; i < 300; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = rnd64();
      rb = ($urandom_range(0, 7) == 0) ? ra : rnd64();
      run_model("rand", ra, rb, 3'($urandom_range(0, 7)));
    end

    // Async reset mid-stream: clears before any clock edge.
    run_model("pre_rst", MAXP, MAXP, 3'b010);
    @(negedge clk);
    A     = 64'd7;
    B     = 64'd3;
    cntrl = 3'b011;
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", observed(), 68'd0);
    @(posedge clk);
    #1;
    check("rst_hold", observed(), 68'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release", observed(), {64'd4, 4'b0001});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
